// File: rtl/gb_int_pkg.sv
// Shared constants and state encodings for the Game Boy style interrupt controller.
// Bit indices, jump vectors, register addresses and FSM state types live here.
package gb_int_pkg;

  localparam logic [2:0] INT_VBLANK = 3'd0;
  localparam logic [2:0] INT_STAT   = 3'd1;
  localparam logic [2:0] INT_TIMER  = 3'd2;
  localparam logic [2:0] INT_SERIAL = 3'd3;
  localparam logic [2:0] INT_JOYPAD = 3'd4;

  localparam logic [7:0] VEC_VBLANK = 8'h40;
  localparam logic [7:0] VEC_STAT   = 8'h48;
  localparam logic [7:0] VEC_TIMER  = 8'h50;
  localparam logic [7:0] VEC_SERIAL = 8'h58;
  localparam logic [7:0] VEC_JOYPAD = 8'h60;
  localparam logic [7:0] VEC_NONE   = 8'h00;

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  typedef enum logic [1:0] {
    IME_OFF   = 2'd0,
    IME_ARMED = 2'd1,
    IME_ON    = 2'd2
  } ime_state_t;

  typedef enum logic {
    DISP_IDLE      = 1'b0,
    DISP_SERVICING = 1'b1
  } disp_state_t;

  // Jump target low byte for interrupt index n: 0x40 + 8*n.
  function automatic logic [7:0] vector_for(input logic [2:0] idx);
    return VEC_VBLANK + {2'b00, idx, 3'b000};
  endfunction

endpackage

// File: rtl/int_priority_encoder.sv
// Picks the lowest-numbered pending interrupt; bit 0 (VBlank) has highest priority.
module int_priority_encoder
  import gb_int_pkg::*;
(
  input  logic [4:0] i_Pending,
  output logic [2:0] o_Index,
  output logic       o_Valid
);

  always_comb begin
    o_Valid = |i_Pending;
    o_Index = INT_VBLANK;
    if (i_Pending[0])      o_Index = INT_VBLANK;
    else if (i_Pending[1]) o_Index = INT_STAT;
    else if (i_Pending[2]) o_Index = INT_TIMER;
    else if (i_Pending[3]) o_Index = INT_SERIAL;
    else if (i_Pending[4]) o_Index = INT_JOYPAD;
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: IF/IE registers, IME enable FSM with EI delay, and the
// dispatch FSM that hands the CPU a vector on acknowledge.
//
// Handshake: o_Int_Request is a level that stays high while a dispatch is wanted;
// the control unit answers with a one-cycle i_Int_Ack. The ack is accepted only in
// IDLE (no dependency on o_Int_Request, so a late ack yields the cancelled vector
// 0x00); i_Service_Done closes the transaction and re-opens the handshake.
module interrupt_controller
  import gb_int_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic       i_Enable,
  input  logic [4:0] i_Int_Request,
  input  logic       i_Sel_IF,
  input  logic       i_Sel_IE,
  input  logic       i_Write,
  input  logic [7:0] i_Data,
  output logic [7:0] o_Data,
  input  logic       i_EI,
  input  logic       i_DI,
  input  logic       i_RETI,
  input  logic       i_Instr_Boundary,
  input  logic       i_Int_Ack,
  input  logic       i_Service_Done,
  output logic [4:0] o_Interrupts,
  output logic       o_Int_Request,
  output logic [7:0] o_Vector,
  output logic       o_Wake,
  output logic       o_IME,
  output logic [1:0] o_Dbg_Ime_State,
  output logic       o_Dbg_Dispatch_State
);

  logic [4:0]  if_q;
  logic [7:0]  ie_q;
  ime_state_t  ime_q;
  logic        ime_on_q;
  disp_state_t disp_q;
  logic [7:0]  vector_q;

  logic [4:0]  pending;
  logic [2:0]  win_idx;
  logic        win_valid;
  logic        ack_take;
  logic [4:0]  ack_clear;
  logic [4:0]  if_next;

  assign pending  = ie_q[4:0] & if_q;
  assign ack_take = i_Int_Ack && (disp_q == DISP_IDLE);

  int_priority_encoder u_prio (
    .i_Pending (pending),
    .o_Index   (win_idx),
    .o_Valid   (win_valid)
  );

  // A new request pulse beats both a CPU write-clear and the ack-clear of its bit.
  always_comb begin
    ack_clear = 5'b00000;
    if (ack_take && win_valid) ack_clear = 5'b00001 << win_idx;
    if_next = if_q;
    if (i_Write && i_Sel_IF) if_next = i_Data[4:0];
    if_next = (if_next & ~ack_clear) | i_Int_Request;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      if_q <= 5'h00;
      ie_q <= 8'h00;
    end else if (i_Enable) begin
      if_q <= if_next;
      if (i_Write && i_Sel_IE) ie_q <= i_Data;
    end
  end

  // IME: DI and a taken ack both disable; RETI enables at once; EI only arms and
  // the enable lands at the next instruction boundary.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      ime_q    <= IME_OFF;
      ime_on_q <= 1'b0;
    end else if (i_Enable) begin
      if (i_DI || ack_take) begin
        ime_q    <= IME_OFF;
        ime_on_q <= 1'b0;
      end else if (i_RETI) begin
        ime_q    <= IME_ON;
        ime_on_q <= 1'b1;
      end else begin
        case (ime_q)
          IME_OFF: begin
            if (i_EI) ime_q <= IME_ARMED;
          end
          IME_ARMED: begin
            if (i_Instr_Boundary) begin
              ime_q    <= IME_ON;
              ime_on_q <= 1'b1;
            end
          end
          IME_ON: begin
            ime_on_q <= 1'b1;
          end
          default: begin
            ime_q    <= IME_OFF;
            ime_on_q <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      disp_q   <= DISP_IDLE;
      vector_q <= VEC_NONE;
    end else if (i_Enable) begin
      case (disp_q)
        DISP_IDLE: begin
          if (i_Int_Ack) begin
            disp_q   <= DISP_SERVICING;
            vector_q <= win_valid ? vector_for(win_idx) : VEC_NONE;
          end
        end
        DISP_SERVICING: begin
          if (i_Service_Done) disp_q <= DISP_IDLE;
        end
        default: disp_q <= DISP_IDLE;
      endcase
    end
  end

  always_comb begin
    o_Data = 8'h00;
    if (i_Sel_IF)      o_Data = {3'b111, if_q};
    else if (i_Sel_IE) o_Data = ie_q;
  end

  assign o_Interrupts         = pending;
  assign o_Wake               = |pending;
  assign o_Int_Request        = (disp_q == DISP_IDLE) && ime_on_q && (|pending);
  assign o_Vector             = vector_q;
  assign o_IME                = ime_on_q;
  assign o_Dbg_Ime_State      = ime_q;
  assign o_Dbg_Dispatch_State = disp_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios then random traffic, all
// checked against a behavioural model of IF/IE, IME and dispatch.
module tb_interrupt_controller;
  import gb_int_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b1;
  logic [4:0] int_request = '0;
  logic       sel_if = 1'b0, sel_ie = 1'b0, write = 1'b0;
  logic [7:0] data = '0;
  logic       ei = 1'b0, di = 1'b0, reti = 1'b0, boundary = 1'b0, ack = 1'b0, done = 1'b0;
  logic [7:0] rd_data, vector;
  logic [4:0] interrupts;
  logic       int_req_out, wake, ime;
  logic [1:0] dbg_ime;
  logic       dbg_disp;

  int n_checks = 0;
  int n_fails = 0;
  logic [7:0] exp_q[$];

  // Model state: IME kept as two flags (enabled, enable-pending).
  logic [4:0] m_if;
  logic [7:0] m_ie;
  logic       m_on, m_armed, m_busy;
  logic [7:0] m_vec;
  bit         m_known = 0;

  interrupt_controller dut (
    .i_Clk(clk), .i_Reset_n(reset_n), .i_Enable(enable), .i_Int_Request(int_request),
    .i_Sel_IF(sel_if), .i_Sel_IE(sel_ie), .i_Write(write), .i_Data(data), .o_Data(rd_data),
    .i_EI(ei), .i_DI(di), .i_RETI(reti), .i_Instr_Boundary(boundary), .i_Int_Ack(ack),
    .i_Service_Done(done), .o_Interrupts(interrupts), .o_Int_Request(int_req_out),
    .o_Vector(vector), .o_Wake(wake), .o_IME(ime), .o_Dbg_Ime_State(dbg_ime),
    .o_Dbg_Dispatch_State(dbg_disp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [4:0] pend;
    logic [7:0] rd_exp;
    logic [1:0] ime_exp;
    pend = m_ie[4:0] & m_if;
    rd_exp = sel_if ? {3'b111, m_if} : (sel_ie ? m_ie : 8'h00);
    ime_exp = m_on ? IME_ON : (m_armed ? IME_ARMED : IME_OFF);
    chk("interrupts", {3'b000, interrupts}, {3'b000, pend});
    chk("wake", {7'd0, wake}, {7'd0, (pend != 0)});
    chk("int_request", {7'd0, int_req_out}, {7'd0, (!m_busy && m_on && pend != 0)});
    chk("ime", {7'd0, ime}, {7'd0, m_on});
    chk("read_data", rd_data, rd_exp);
    chk("vector", vector, m_vec);
    chk("dbg_ime", {6'd0, dbg_ime}, {6'd0, ime_exp});
    chk("dbg_disp", {7'd0, dbg_disp}, {7'd0, m_busy});
  endtask

  // One clock: check outputs mid-cycle, advance the model, commit after the edge.
  task automatic tick();
    logic [4:0] n_if;
    logic [7:0] n_ie, n_vec;
    logic       n_on, n_armed, n_busy, take, pushed;
    int         win;
    #1;
    if (m_known) check_outputs();
    n_if = m_if; n_ie = m_ie; n_on = m_on; n_armed = m_armed;
    n_busy = m_busy; n_vec = m_vec; pushed = 0;
    if (!reset_n) begin
      n_if = 0; n_ie = 0; n_on = 0; n_armed = 0; n_busy = 0; n_vec = 0;
    end else if (enable) begin
      take = ack && !m_busy;
      win = -1;
      for (int b = 4; b >= 0; b--) if (m_ie[b] && m_if[b]) win = b;
      if (write && sel_if) n_if = data[4:0];
      if (write && sel_ie) n_ie = data;
      if (take) begin
        n_busy = 1;
        n_vec = (win >= 0) ? 8'(8'h40 + 8 * win) : 8'h00;
        if (win >= 0) n_if[win] = 1'b0;
        exp_q.push_back(n_vec);
        pushed = 1;
      end else if (m_busy && done) begin
        n_busy = 0;
      end
      n_if = n_if | int_request;
      if (di || take) begin
        n_on = 0; n_armed = 0;
      end else if (reti) begin
        n_on = 1; n_armed = 0;
      end else if (ei && !m_on && !m_armed) begin
        n_armed = 1;
      end else if (m_armed && boundary) begin
        n_on = 1; n_armed = 0;
      end
    end
    @(posedge clk);
    #1;
    m_if = n_if; m_ie = n_ie; m_on = n_on; m_armed = n_armed; m_busy = n_busy; m_vec = n_vec;
    if (!reset_n) m_known = 1;
    if (pushed) chk("ack_vector", vector, exp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic idle();
    int_request = '0; sel_if = 0; sel_ie = 0; write = 0; data = '0;
    ei = 0; di = 0; reti = 0; boundary = 0; ack = 0; done = 0; enable = 1; reset_n = 1;
  endtask

  task automatic do_reset();
    idle(); reset_n = 0; tick(); reset_n = 1;
  endtask

  task automatic wr_ie(input logic [7:0] v);
    idle(); sel_ie = 1; write = 1; data = v; tick(); idle();
  endtask

  task automatic read_if(input string tag, input logic [7:0] exp);
    idle(); sel_if = 1; #1; chk(tag, rd_data, exp); tick(); idle();
  endtask

  initial begin
    int s;
    @(negedge clk);
    reset_n = 0; enable = 0; tick(); tick();
    idle();
    read_if("reset_if", 8'hE0);
    sel_ie = 1; #1; chk("reset_ie", rd_data, 8'h00); idle();

    // Two requests together, VBlank wins.
    do_reset(); wr_ie(8'h05);
    reti = 1; tick(); idle();
    int_request = 5'h05; tick(); idle();
    ack = 1; tick(); idle();
    chk("prio_vector", vector, 8'h40);
    chk("prio_ime", {7'd0, ime}, 8'h00);
    read_if("prio_if", 8'hE4);
    done = 1; tick(); idle();

    // EI delay: request only after the boundary.
    do_reset(); wr_ie(8'h01);
    int_request = 5'h01; tick(); idle();
    ei = 1; tick(); idle();
    boundary = 1; #1; chk("ei_boundary_cycle", {7'd0, int_req_out}, 8'h00);
    tick(); idle();
    chk("ei_after_boundary", {7'd0, int_req_out}, 8'h01);

    // EI then DI: never asserted.
    do_reset(); wr_ie(8'h01);
    int_request = 5'h01; tick(); idle();
    ei = 1; tick(); idle();
    di = 1; tick(); idle();
    for (int i = 0; i < 3; i++) begin
      boundary = 1; tick(); idle();
      chk("ei_di_never", {7'd0, int_req_out}, 8'h00);
    end

    // Cancelled dispatch.
    do_reset(); wr_ie(8'h02);
    int_request = 5'h02; tick(); idle();
    reti = 1; tick(); idle();
    chk("cancel_req_before", {7'd0, int_req_out}, 8'h01);
    sel_if = 1; write = 1; data = 8'h00; tick(); idle();
    ack = 1; tick(); idle();
    chk("cancel_vector", vector, 8'h00);
    chk("cancel_ime", {7'd0, ime}, 8'h00);
    read_if("cancel_if", 8'hE0);
    done = 1; tick(); idle();

    // Request beats write-clear.
    do_reset();
    sel_if = 1; write = 1; data = 8'h00; int_request = 5'h08; tick(); idle();
    read_if("req_wins_write", 8'hE8);

    // Wake without IME, then RETI.
    do_reset(); wr_ie(8'h10);
    int_request = 5'h10; tick(); idle();
    chk("wake_set", {7'd0, wake}, 8'h01);
    chk("wake_no_req", {7'd0, int_req_out}, 8'h00);
    reti = 1; tick(); idle();
    chk("reti_req", {7'd0, int_req_out}, 8'h01);

    // Reset during servicing.
    do_reset(); wr_ie(8'h1F);
    int_request = 5'h1F; tick(); idle();
    reti = 1; tick(); idle();
    ack = 1; tick(); idle();
    int_request = 5'h01; tick(); idle();
    read_if("svc_if_full", 8'hFF);
    chk("svc_state", {7'd0, dbg_disp}, 8'h01);
    reset_n = 0; enable = 0; tick(); idle();
    chk("rst_svc_wake", {7'd0, wake}, 8'h00);
    chk("rst_svc_req", {7'd0, int_req_out}, 8'h00);
    chk("rst_svc_ints", {3'd0, interrupts}, 8'h00);
    chk("rst_svc_disp", {7'd0, dbg_disp}, 8'h00);
    chk("rst_svc_vector", vector, 8'h00);
    read_if("rst_svc_if", 8'hE0);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      reset_n = ($urandom_range(0, 63) != 0);
      enable = ($urandom_range(0, 7) != 0);
      int_request = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
      s = $urandom_range(0, 3);
      sel_if = (s == 1); sel_ie = (s == 2);
      write = ($urandom_range(0, 3) == 0);
      data = 8'($urandom);
      ei = ($urandom_range(0, 7) == 0);
      di = ($urandom_range(0, 11) == 0);
      reti = ($urandom_range(0, 15) == 0);
      boundary = ($urandom_range(0, 2) == 0);
      ack = ($urandom_range(0, 5) == 0);
      done = ($urandom_range(0, 4) == 0);
      tick();
    end
    idle(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have ports: i_Clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have ports: i_Reset_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: i_Enable  in  1  clock enable; when low, no state changes (reset still honoured).
REQ-004 SHALL have ports: i_Int_Request  in  5  one-cycle request pulses; bit0 VBlank, 1 LCD STAT, 2 Timer, 3 Serial, 4 Joypad.
REQ-005 SHALL have ports: i_Sel_IF / i_Sel_IE  in  1 each  register select (0xFF0F / 0xFFFF), mutually exclusive.
REQ-006 SHALL have ports: i_Write  in  1  write strobe for the selected register; i_Data  in  8  write data; o_Data  out  8  read data.
REQ-007 SHALL have ports: i_EI, i_DI, i_RETI  in  1 each  IME control pulses from the control unit.
REQ-008 SHALL have ports: i_Instr_Boundary  in  1  pulse at each opcode fetch (end of instruction).
REQ-009 SHALL have ports: i_Int_Ack  in  1  dispatch acknowledge pulse; i_Service_Done  in  1  vector jump complete.
REQ-010 SHALL have ports: o_Interrupts  out  5  IE&IF, drives the control unit's i_Interrupts.
REQ-011 SHALL have ports: o_Int_Request  out  1  dispatch request; o_Vector  out  8  low byte of jump target; o_Wake  out  1  HALT wake; o_IME  out  1.

Function
REQ-012 IF (5b) SHALL set bit n on i_Int_Request[n]; CPU write to IF loads i_Data[4:0]; in the same cycle, request set SHALL win over write-clear and ack-clear of that bit.
REQ-013 IE (8b) SHALL load all 8 bits of i_Data on write.
REQ-014 o_Data SHALL be {3'b111, IF} when i_Sel_IF, IE when i_Sel_IE, 8'h00 otherwise; combinational.
REQ-015 IME FSM states OFF, ARMED, ON: EI in OFF -> ARMED; ARMED + i_Instr_Boundary -> ON; EI in ARMED/ON SHALL not change state; EI and i_Instr_Boundary in same cycle from OFF -> ARMED only.
REQ-016 DI SHALL force OFF from any state next cycle, cancelling ARMED; RETI SHALL force ON next cycle; DI and RETI together -> OFF.
REQ-017 o_IME SHALL be high only in ON.
REQ-018 Dispatch FSM states IDLE, SERVICING: o_Int_Request = IDLE & IME ON & |(IE[4:0]&IF).
REQ-019 i_Int_Ack in IDLE SHALL: take lowest-numbered set bit of IE&IF (bit0 highest priority), clear that IF bit, set IME OFF, latch o_Vector = 8'h40 + 8*n, enter SERVICING; all in one cycle.
REQ-020 i_Int_Ack with IE&IF == 0 at ack time (cancelled dispatch) SHALL latch o_Vector = 8'h00, clear IME, clear no IF bit, enter SERVICING.
REQ-021 i_Int_Ack in SERVICING SHALL be ignored; i_Service_Done SHALL return to IDLE; o_Vector holds until next ack.
REQ-022 o_Wake SHALL be |(IE[4:0]&IF) independent of IME and FSM state; combinational.
REQ-023 o_Interrupts SHALL be IE[4:0]&IF, combinational.

Reset
REQ-024 On i_Reset_n low at clock edge: IF=5'h00, IE=8'h00, IME OFF, dispatch IDLE, o_Vector=8'h00; i_Enable not required.
REQ-025 Reset mid-SERVICING SHALL abandon dispatch; resulting outputs o_Int_Request=0, o_Wake=0, o_IME=0, o_Interrupts=0.

Structure
REQ-026 Shared package gb_int_pkg SHALL hold interrupt bit indices, vector constants (0x40..0x60), register addresses 0xFF0F/0xFFFF, IME and dispatch state encodings.
REQ-027 One sub-module int_priority_encoder (5-bit in -> 3-bit index + valid) SHALL be used; everything else in interrupt_controller.

Verification
REQ-028 IE=0x05, IME ON, pulse requests 0x04 then 0x01 same cycle, ack -> o_Vector=0x40, IF=0x04, IME OFF.
REQ-029 EI, then i_Instr_Boundary next cycle, IE=IF=0x01 -> o_Int_Request high only from the cycle after the boundary; EI immediately followed by DI -> never asserted.
REQ-030 IME ON, IE=0x02, IF=0x02; CPU writes IF=0x00 in cycle before ack -> ack yields o_Vector=0x00, IF=0x00, IME OFF.
REQ-031 Write IF=0x00 and i_Int_Request=0x08 same cycle -> IF=0x08; IF read -> 0xE8.
REQ-032 IME OFF, IE=0x10, request 0x10 -> o_Wake=1, o_Int_Request=0; RETI -> o_Int_Request=1 next cycle.
REQ-033 Reset asserted in SERVICING with IF=0x1F -> next cycle all registers zero, state IDLE, o_Wake=0.
